// File: rtl/alu_pkg.sv
// Shared opcode encoding, FSM state type and latency classification for the
// shared-ALU arbiter.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_XOR = 5'b00100;
  localparam logic [4:0] OP_MUL = 5'b00101;
  localparam logic [4:0] OP_DIV = 5'b00111;
  localparam logic [4:0] OP_NOT = 5'b01000;
  localparam logic [4:0] OP_MOD = 5'b01001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    LAT_UNIT,
    LAT_MUL,
    LAT_DIV
  } lat_class_t;

  function automatic lat_class_t is_long_op(input logic [4:0] op);
    lat_class_t cls;
    cls = LAT_UNIT;
    if (op == OP_MUL) cls = LAT_MUL;
    else if ((op == OP_DIV) || (op == OP_MOD)) cls = LAT_DIV;
    return cls;
  endfunction

  function automatic logic op_defined(input logic [4:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_MUL, OP_DIV, OP_NOT, OP_MOD: ok = 1'b1;
      default:                         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu16.sv
// Combinational 16-bit ALU. Results are truncated to 16 bits; undefined
// opcodes produce zero.
module alu16
  import alu_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [4:0]  op,
  output logic [15:0] y
);

  always_comb begin
    y = 16'h0000;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_MUL: y = a * b;
      // Zero divisor gets a fixed value so the datapath never goes X.
      OP_DIV: y = (b == 16'h0000) ? 16'hFFFF : a / b;
      OP_MOD: y = (b == 16'h0000) ? a : a % b;
      OP_NOT: y = ~a;
      default: y = 16'h0000;
    endcase
  end

endmodule

// File: rtl/alu_rr_arb.sv
// Combinational round-robin picker: first valid requester scanning upward
// from last+1, wrapping modulo NREQ.
module alu_rr_arb #(
  parameter  int NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!any && valid[IW'((int'(last) + k) % NREQ)]) begin
        any   = 1'b1;
        idx   = IW'((int'(last) + k) % NREQ);
        grant[IW'((int'(last) + k) % NREQ)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one alu16 among NREQ requesters, one op in flight.
// Optional macro ALU_ARB_CHECK_EN flags divide-by-zero and undefined opcodes.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int NREQ    = 2,
  parameter  int MUL_LAT = 2,
  parameter  int DIV_LAT = 4,
  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  input  logic [5*NREQ-1:0]  req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IW-1:0]    rsp_id,
  output logic [15:0]      rsp_result,
  output logic             rsp_err,
  output logic             busy
);

  localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  logic [15:0] a_arr  [NREQ];
  logic [15:0] b_arr  [NREQ];
  logic [4:0]  op_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi]  = req_a[gi*16 +: 16];
      assign b_arr[gi]  = req_b[gi*16 +: 16];
      assign op_arr[gi] = req_op[gi*5 +: 5];
    end
  endgenerate

  arb_state_t  state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [15:0] a_reg, a_next;
  logic [15:0] b_reg, b_next;
  logic [4:0]  op_reg, op_next;
  logic [IW-1:0] id_reg, id_next;
  logic [IW-1:0] last_reg, last_next;
  logic [15:0] result_reg, result_next;
  logic        err_reg, err_next;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic [15:0]     alu_y;
  logic [15:0]     cap_result;
  logic            cap_err;
  logic [CW-1:0]   load_lat;

  alu_rr_arb #(.NREQ(NREQ)) u_arb (
    .valid (req_valid),
    .last  (last_reg),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // The ALU sees only latched operands, so requesters may change inputs freely.
  alu16 u_alu (
    .a  (a_reg),
    .b  (b_reg),
    .op (op_reg),
    .y  (alu_y)
  );

`ifdef ALU_ARB_CHECK_EN
  always_comb begin
    cap_result = alu_y;
    cap_err    = 1'b0;
    if (((op_reg == OP_DIV) || (op_reg == OP_MOD)) && (b_reg == 16'h0000)) begin
      cap_result = 16'hFFFF;
      cap_err    = 1'b1;
    end else if (!op_defined(op_reg)) begin
      cap_result = 16'h0000;
      cap_err    = 1'b1;
    end
  end
`else
  assign cap_result = alu_y;
  assign cap_err    = 1'b0;
`endif

  always_comb begin
    case (is_long_op(op_arr[grant_idx]))
      LAT_MUL: load_lat = CW'(MUL_LAT);
      LAT_DIV: load_lat = CW'(DIV_LAT);
      default: load_lat = CW'(1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      id_reg     <= '0;
      last_reg   <= IW'(NREQ - 1);
      result_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      op_reg     <= op_next;
      id_reg     <= id_next;
      last_reg   <= last_next;
      result_reg <= result_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    op_next     = op_reg;
    id_next     = id_reg;
    last_next   = last_reg;
    result_next = result_reg;
    err_next    = err_reg;
    req_ready   = '0;
    case (state_reg)
      ST_IDLE: begin
        if (grant_any) begin
          req_ready  = grant;
          a_next     = a_arr[grant_idx];
          b_next     = b_arr[grant_idx];
          op_next    = op_arr[grant_idx];
          id_next    = grant_idx;
          last_next  = grant_idx;
          cnt_next   = load_lat;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_reg == CW'(1)) begin
          result_next = cap_result;
          err_next    = cap_err;
          state_next  = ST_RESP;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rsp_valid  = (state_reg == ST_RESP);
  assign busy       = (state_reg != ST_IDLE);
  assign rsp_id     = id_reg;
  assign rsp_result = result_reg;
  assign rsp_err    = err_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (NREQ=3) against a behavioural model of
// arithmetic, latency and round-robin order.
module tb_alu_arbiter;

  localparam int NREQ    = 3;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 4;

  localparam logic [4:0] ADD   = 5'b00000;
  localparam logic [4:0] SUB   = 5'b00001;
  localparam logic [4:0] AND_  = 5'b00010;
  localparam logic [4:0] OR_   = 5'b00011;
  localparam logic [4:0] XOR_  = 5'b00100;
  localparam logic [4:0] MUL   = 5'b00101;
  localparam logic [4:0] UNDEF = 5'b00110;
  localparam logic [4:0] DIV   = 5'b00111;
  localparam logic [4:0] NOT_  = 5'b01000;
  localparam logic [4:0] MOD   = 5'b01001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid, req_ready;
  logic [47:0] req_a, req_b;
  logic [14:0] req_op;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_result;
  logic        rsp_err, busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int m_last;

  logic [15:0] op_a [3];
  logic [15:0] op_b [3];
  logic [4:0]  op_c [3];
  logic [4:0]  op_list [9] = '{ADD, SUB, AND_, OR_, XOR_, MUL, DIV, NOT_, MOD};

  alu_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic on plain unsigned integers, truncated mod 2^16.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [4:0] op);
    int unsigned ua = a;
    int unsigned ub = b;
    int unsigned r  = 0;
    logic e = 1'b0;
    case (op)
      ADD:  r = (ua + ub) % 65536;
      SUB:  r = (ua + 65536 - ub) % 65536;
      AND_: r = ua & ub;
      OR_:  r = ua | ub;
      XOR_: r = ua ^ ub;
      MUL:  r = (ua * ub) % 65536;
      NOT_: r = 65535 - ua;
      DIV:  if (ub == 0) begin r = 65535; e = 1'b1; end else r = ua / ub;
      MOD:  if (ub == 0) begin r = 65535; e = 1'b1; end else r = ua % ub;
      default: begin r = 0; e = 1'b1; end
    endcase
    return {e, r[15:0]};
  endfunction

  function automatic int lat(input logic [4:0] op);
    if (op == MUL) return MUL_LAT;
    if (op == DIV || op == MOD) return DIV_LAT;
    return 1;
  endfunction

  function automatic int pick(input logic [2:0] mask);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic pack();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*16 +: 16] = op_a[i];
      req_b[i*16 +: 16] = op_b[i];
      req_op[i*5 +: 5]  = op_c[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = 16'($urandom);
      op_b[i] = 16'($urandom);
      op_c[i] = op_list[$urandom_range(0, 8)];
      if ((op_c[i] == DIV || op_c[i] == MOD) && op_b[i] == 16'h0) op_b[i] = 16'h0001;
    end
  endtask

  // One transaction: offer mask, check grant, scramble inputs, wait for the
  // response, optionally stall it for 'stall' cycles, then drain.
  task automatic run_txn(input logic [2:0] mask, input string tag, input int stall);
    int g, n, l;
    logic [16:0] exp;
    rsp_ready = (stall == 0);
    @(negedge clk);
    req_valid = mask;
    pack();
    #1;
    g = pick(mask);
    chk({tag, " grant"}, 32'(req_ready), 32'(1 << g));
    exp = model(op_a[g], op_b[g], op_c[g]);
    l   = lat(op_c[g]);
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    m_last = g;
    rand_ops();
    pack();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 40);
    chk({tag, " latency"}, 32'(n), 32'(l + 1));
    chk({tag, " id"}, 32'(rsp_id), 32'(g));
    chk({tag, " result"}, 32'(rsp_result), 32'(exp[15:0]));
    chk({tag, " err"}, 32'(rsp_err), 32'(exp[16]));
    if (stall > 0) begin
      req_valid = 3'b111;
      for (int c = 0; c < stall; c++) begin
        @(negedge clk);
        chk({tag, " stall hold"},
            {12'h0, rsp_valid, busy, rsp_err, rsp_id, req_ready, rsp_result},
            {12'h0, 1'b1, 1'b1, exp[16], 2'(g), 3'b000, exp[15:0]});
      end
      req_valid = 3'b000;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({tag, " drain"}, 32'(rsp_valid), 32'(0));
    if (stall > 0) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk({tag, " single handshake"}, {30'h0, rsp_valid, busy}, 32'(0));
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 3'b000;
    rsp_ready = 1'b1;
    m_last    = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_c[i] = ADD;
    end
    pack();
    repeat (2) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'(0));
    chk("reset rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset rsp_id", 32'(rsp_id), 32'(0));
    chk("reset rsp_result", 32'(rsp_result), 32'(0));
    chk("reset rsp_err", 32'(rsp_err), 32'(0));
    chk("reset busy", 32'(busy), 32'(0));
    rst_n = 1'b1;

    op_a[0] = 16'h1234; op_b[0] = 16'h0001; op_c[0] = ADD;
    run_txn(3'b001, "add", 0);
    op_a[1] = 16'h0100; op_b[1] = 16'h0100; op_c[1] = MUL;
    run_txn(3'b010, "mul", 0);
    op_a[2] = 16'd100;  op_b[2] = 16'd7;    op_c[2] = DIV;
    run_txn(3'b100, "div", 0);

    for (int t = 0; t < 6; t++) begin
      rand_ops();
      run_txn(3'b111, "rr", 0);
    end

    rand_ops();
    op_a[0] = 16'hBEEF; op_b[0] = 16'h1234; op_c[0] = XOR_;
    run_txn(3'b011, "backpressure", 10);

    for (int t = 0; t < 20; t++) begin
      rand_ops();
      run_txn(3'($urandom_range(1, 7)), "random", 0);
    end

`ifdef ALU_ARB_CHECK_EN
    rand_ops();
    op_a[m_last == 0 ? 1 : 0] = 16'd5;
    op_b[m_last == 0 ? 1 : 0] = 16'd0;
    op_c[m_last == 0 ? 1 : 0] = MOD;
    run_txn(m_last == 0 ? 3'b010 : 3'b001, "mod0", 0);
    rand_ops();
    op_c[2] = UNDEF;
    run_txn(3'b100, "undef", 0);
`endif

    // Abort a DIV in its second EXEC cycle with an asynchronous reset.
    op_a[0] = 16'hFFFF; op_b[0] = 16'h0003; op_c[0] = DIV;
    pack();
    @(negedge clk);
    req_valid = 3'b001;
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort outputs",
        {10'h0, req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, busy}, 32'(0));
    @(negedge clk);
    rst_n  = 1'b1;
    m_last = NREQ - 1;
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (rsp_valid || busy) seen = 1'b1;
      end
      chk("no response after abort", 32'(seen), 32'(0));
    end
    rand_ops();
    run_txn(3'b011, "post-reset priority", 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
